// File: rtl/kmap_lut_prog_if.sv
`default_nettype none
// ============================================================================
//  Module      : kmap_lut_prog_if
//  Description : Configuration stream and evaluation bus for kmap_lut_prog.
//                The master drives the serial table load and evaluation
//                requests; the slave (the evaluator) returns the results.
//  Revision    : 1.0 - initial release
// ============================================================================
interface kmap_lut_prog_if #(
    parameter int N_IN = 4,
    parameter int N_CH = 2
);
    logic            cfg_start;
    logic            cfg_valid;
    logic            cfg_bit;
    logic            cfg_ready;
    logic            cfg_done;
    logic            in_valid;
    logic [N_IN-1:0] in_vec;
    logic            out_valid;
    logic [N_CH-1:0] out;
    logic            unarmed;

    modport master (
        output cfg_start, cfg_valid, cfg_bit, in_valid, in_vec,
        input  cfg_ready, cfg_done, out_valid, out, unarmed
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_bit, in_valid, in_vec,
        output cfg_ready, cfg_done, out_valid, out, unarmed
    );
endinterface
`default_nettype wire

// File: rtl/kmap_lut_prog.sv
`default_nettype none
// ============================================================================
//  Module      : kmap_lut_prog
//  Description : Multi-channel programmable truth-table evaluator. Each
//                channel holds an N_IN-input Boolean function in a table
//                loaded serially into a shadow copy and committed atomically
//                to the active copy, so evaluation never stalls on a load.
//                Evaluation results are registered (one-cycle latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module kmap_lut_prog #(
    parameter int N_IN = 4,
    parameter int N_CH = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    kmap_lut_prog_if.slave     bus
);
    localparam int D     = 1 << N_IN;
    localparam int T     = N_CH * D;
    localparam int CNT_W = $clog2(T + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [T-1:0]     shadow_q, shadow_d;
    logic [T-1:0]     active_q, active_d;
    logic             armed_q, armed_d;
    logic             cfg_done_q, cfg_done_d;

    logic             out_valid_q;
    logic [N_CH-1:0]  out_q, out_d;
    logic             unarmed_q;
    logic [N_CH-1:0]  w_bit;

    // Load FSM and table storage state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shadow_q   <= '0;
            active_q   <= '0;
            armed_q    <= 1'b0;
            cfg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            armed_q    <= armed_d;
            cfg_done_q <= cfg_done_d;
        end
    end

    // Next-state logic: accept serial bits into the shadow table and commit
    // the whole table (including the final bit) in the cycle it is accepted.
    // A restart request wins over a coincident final bit.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        active_d   = active_q;
        armed_d    = armed_q;
        cfg_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cfg_start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (bus.cfg_start) begin
                    cnt_d = '0;
                end else if (bus.cfg_valid) begin
                    for (int k = 0; k < T; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            shadow_d[k] = bus.cfg_bit;
                        end
                    end
                    if (cnt_q == CNT_W'(T - 1)) begin
                        active_d   = shadow_d;
                        armed_d    = 1'b1;
                        cfg_done_d = 1'b1;
                        state_d    = S_IDLE;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Per-channel lookup of the active table at the requested minterm
    generate
        for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
            logic [D-1:0] w_row;
            assign w_row     = active_q[ch*D +: D];
            assign w_bit[ch] = w_row[bus.in_vec];
        end
    endgenerate

    // Outputs are forced low until a table has been committed
    always_comb begin
        out_d = armed_q ? w_bit : '0;
    end

    // Evaluation result register; out holds its value between requests
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            unarmed_q   <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                out_q     <= out_d;
                unarmed_q <= ~armed_q;
            end
        end
    end

    assign bus.cfg_ready = (state_q == S_LOAD);
    assign bus.cfg_done  = cfg_done_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.unarmed   = unarmed_q;
endmodule
`default_nettype wire

// File: tb/tb_kmap_lut_prog.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kmap_lut_prog
//  Description : Self-checking bench for kmap_lut_prog. Stimulus pushes the
//                expected evaluation result into a scoreboard; a monitor pops
//                and compares whenever the DUT presents out_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kmap_lut_prog;
    localparam int N_IN = 4;
    localparam int N_CH = 2;
    localparam int D    = 1 << N_IN;
    localparam int T    = N_CH * D;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kmap_lut_prog_if #(.N_IN(N_IN), .N_CH(N_CH)) bus_if ();

    kmap_lut_prog #(.N_IN(N_IN), .N_CH(N_CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int errors = 0;
    int checks = 0;

    // scoreboard entries: {out, unarmed}
    logic [N_CH:0] sb_q[$];

    // behavioural model: the two table copies, the load position, armed flag
    bit m_sh  [T];
    bit m_act [T];
    bit m_armed   = 1'b0;
    bit m_loading = 1'b0;
    int m_k       = 0;

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [N_CH:0] model_eval(input logic [N_IN-1:0] v);
        logic [N_CH-1:0] o;
        o = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (m_armed) o[ch] = m_act[ch*D + int'(v)];
        end
        return {o, ~m_armed};
    endfunction

    // One clock cycle of stimulus; the model advances as the table would
    task automatic step(input bit st, input bit va, input bit b, input bit iv,
                        input logic [N_IN-1:0] vec, input bit r);
        bit exp_done;
        exp_done = 1'b0;
        rst                = r;
        bus_if.cfg_start   = st;
        bus_if.cfg_valid   = va;
        bus_if.cfg_bit     = b;
        bus_if.in_valid    = iv;
        bus_if.in_vec      = vec;
        chk1("cfg_ready", bus_if.cfg_ready, m_loading);
        if (iv && !r) sb_q.push_back(model_eval(vec));
        if (r) begin
            for (int i = 0; i < T; i++) begin
                m_sh[i]  = 1'b0;
                m_act[i] = 1'b0;
            end
            m_armed   = 1'b0;
            m_loading = 1'b0;
            m_k       = 0;
        end else if (m_loading) begin
            if (st) begin
                m_k = 0;
            end else if (va) begin
                m_sh[m_k] = b;
                m_k++;
                if (m_k == T) begin
                    m_act     = m_sh;
                    m_armed   = 1'b1;
                    m_loading = 1'b0;
                    m_k       = 0;
                    exp_done  = 1'b1;
                end
            end
        end else if (st) begin
            m_loading = 1'b1;
            m_k       = 0;
        end
        @(posedge clk);
        #1;
        chk1("cfg_done", bus_if.cfg_done, exp_done);
        chk1("out_valid", bus_if.out_valid, iv && !r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0);
    endtask

    task automatic eval(input logic [N_IN-1:0] v);
        step(0, 0, 0, 1, v, 0);
    endtask

    // mode 0: no evaluation during load, 1: fixed vec every cycle, 2: random
    task automatic load(input logic [T-1:0] w, input bit gapped, input int mode,
                        input logic [N_IN-1:0] fv);
        int  k;
        int  c;
        bit  v;
        bit  iv;
        logic [N_IN-1:0] vec;
        k = 0;
        c = 0;
        iv  = (mode != 0) && (mode == 1 || $urandom_range(1) == 1);
        vec = (mode == 2) ? N_IN'($urandom) : fv;
        step(1, 0, 0, iv, vec, 0);
        while (k < T) begin
            v   = gapped ? (c % 2 == 0) : 1'b1;
            c++;
            iv  = (mode != 0) && (mode == 1 || $urandom_range(1) == 1);
            vec = (mode == 2) ? N_IN'($urandom) : fv;
            step(0, v, w[k], iv, vec, 0);
            if (v) k++;
        end
        // sample in the cfg_done cycle too: must see the new table
        if (mode == 1) eval(fv);
    endtask

    task automatic sweep();
        for (int v = 0; v < D; v++) eval(N_IN'(v));
    endtask

    // Scoreboard monitor, sampling on the falling edge
    always @(negedge clk) begin
        logic [N_CH:0] e;
        if (bus_if.out_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL eval_unexpected: got out=%b unarmed=%b expected no output",
                         bus_if.out, bus_if.unarmed);
            end else begin
                e = sb_q.pop_front();
                if ({bus_if.out, bus_if.unarmed} !== e) begin
                    errors++;
                    $display("FAIL eval: got out=%b unarmed=%b expected out=%b unarmed=%b at %0t",
                             bus_if.out, bus_if.unarmed, e[N_CH:1], e[0], $time);
                end
            end
        end
    end

    initial begin
        logic [T-1:0] tbl;
        rst              = 1'b1;
        bus_if.cfg_start = 1'b0;
        bus_if.cfg_valid = 1'b0;
        bus_if.cfg_bit   = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_vec    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_out_valid", bus_if.out_valid, 1'b0);
        chk1("rst_unarmed", bus_if.unarmed, 1'b0);
        chk1("rst_cfg_done", bus_if.cfg_done, 1'b0);
        checks++;
        if (bus_if.out !== '0) begin
            errors++;
            $display("FAIL rst_out: got %b expected 0", bus_if.out);
        end

        // unarmed evaluation after reset
        step(0, 0, 0, 1, 4'h5, 0);
        idle(1);

        // contiguous load, then full sweep
        tbl = {16'h0FF0, 16'hA5C3};
        load(tbl, 0, 0, '0);
        sweep();

        // gapped load of the same table with random evaluation alongside
        load(tbl, 1, 2, '0);
        sweep();

        // double buffering: old function served until commit
        load({16'h0FF0, 16'hFFFF}, 0, 1, 4'h1);
        load(tbl, 0, 0, '0);
        load({16'h0FF0, 16'hFFFF}, 0, 1, 4'h2);
        sweep();

        // restart coinciding with the final bit: no commit
        tbl = {16'h1234, 16'h8001};
        step(1, 0, 0, 0, '0, 0);
        for (int k = 0; k < T - 1; k++) step(0, 1, tbl[k], 0, '0, 0);
        step(1, 1, tbl[T-1], 1, 4'h3, 0);
        eval(4'h0);
        sweep();
        step(1, 0, 0, 0, '0, 0);
        for (int k = 0; k < T; k++) step(0, 1, tbl[k], 0, '0, 0);
        sweep();

        // reset in the middle of a load
        step(1, 0, 0, 0, '0, 0);
        for (int k = 0; k < 10; k++) step(0, 1, 1'b1, 0, '0, 0);
        step(0, 0, 0, 0, '0, 1);
        eval(4'h7);
        eval(4'hF);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(60) == 0, $urandom_range(3) != 0, 1'($urandom),
                 $urandom_range(1) == 1, N_IN'($urandom), $urandom_range(400) == 0);
        end
        sweep();
        idle(3);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
